// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared types and arithmetic helpers for matvec_stream (MATVEC_SAT_EN selects clamping)
package matvec_pkg;

  typedef enum logic [2:0] {S_IDLE, S_LD_M, S_LD_V, S_MAC, S_OUT} state_t;

  localparam int SAT_W = 64;

  function automatic int acc_width(input int k, input int iw);
    return 2 * iw + $clog2(k);
  endfunction

  // Caller keeps the low ow bits of the return value; acc is a sign-extended accumulator.
  function automatic logic signed [SAT_W-1:0] sat_or_wrap(input logic signed [SAT_W-1:0] acc,
                                                          input int ow);
`ifdef MATVEC_SAT_EN
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
`else
    return acc & ((64'sd1 <<< ow) - 64'sd1);
`endif
  endfunction

endpackage

// File: rtl/matvec_mac.sv
// rtl/matvec_mac.sv - registered signed MAC with clear/enable and a saturating or wrapping output stage
module matvec_mac
  import matvec_pkg::*;
#(
  parameter int IW = 14,
  parameter int OW = 28,
  parameter int AW = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 load,
  input  logic signed [IW-1:0] a,
  input  logic signed [IW-1:0] b,
  output logic signed [OW-1:0] result
);

  logic signed [2*IW-1:0] prod;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   next_acc;

  assign prod     = a * b;
  assign next_acc = acc + AW'(prod);

  // load captures the final sum including the current product, so clear may coincide with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clr)
        acc <= '0;
      else if (en)
        acc <= next_acc;
      if (load)
        result <= OW'(sat_or_wrap(SAT_W'(next_acc), OW));
    end
  end

endmodule

// File: rtl/matvec_stream.sv
// rtl/matvec_stream.sv - streaming signed KxK matrix-vector multiplier (optional MATVEC_SAT_EN output clamp)
module matvec_stream
  import matvec_pkg::*;
#(
  parameter int K  = 8,
  parameter int IW = 14,
  parameter int OW = 28
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic signed [IW-1:0] input_data,
  input  logic                 new_matrix,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic signed [OW-1:0] output_data
);

  localparam int AW   = acc_width(K, IW);
  localparam int CW   = $clog2(K);
  localparam int IDXW = $clog2(K * K);

  state_t              state;
  logic [IDXW-1:0]     idx;
  logic [CW-1:0]       row;
  logic [CW-1:0]       col;
  logic signed [IW-1:0] mat [0:K*K-1];
  logic signed [IW-1:0] vec [0:K-1];

  logic accept;
  logic last_col;
  logic mac_clr;
  logic mac_en;
  logic signed [IW-1:0] m_word;
  logic signed [IW-1:0] x_word;

  assign accept   = input_valid && input_ready;
  assign last_col = (col == CW'(K - 1));
  assign mac_en   = (state == S_MAC);
  assign mac_clr  = (state == S_LD_V && accept && idx == IDXW'(K - 1)) || (mac_en && last_col);
  assign m_word   = mat[IDXW'(row) * IDXW'(K) + IDXW'(col)];
  assign x_word   = vec[col];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      row          <= '0;
      col          <= '0;
      input_ready  <= 1'b0;
      output_valid <= 1'b0;
      for (int i = 0; i < K * K; i++) mat[i] <= '0;
      for (int i = 0; i < K; i++) vec[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          input_ready <= 1'b1;
          if (accept) begin
            idx <= IDXW'(1);
            if (new_matrix) begin
              mat[0] <= input_data;
              state  <= S_LD_M;
            end else begin
              vec[0] <= input_data;
              state  <= S_LD_V;
            end
          end
        end
        S_LD_M: begin
          if (accept) begin
            mat[idx] <= input_data;
            if (idx == IDXW'(K * K - 1)) begin
              idx   <= '0;
              state <= S_LD_V;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_LD_V: begin
          if (accept) begin
            vec[idx[CW-1:0]] <= input_data;
            if (idx == IDXW'(K - 1)) begin
              idx         <= '0;
              row         <= '0;
              col         <= '0;
              input_ready <= 1'b0;
              state       <= S_MAC;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_MAC: begin
          if (last_col) begin
            col          <= '0;
            output_valid <= 1'b1;
            state        <= S_OUT;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_OUT: begin
          // result and valid hold here until the sink takes them
          if (output_ready) begin
            output_valid <= 1'b0;
            if (row == CW'(K - 1)) begin
              row         <= '0;
              input_ready <= 1'b1;
              state       <= S_IDLE;
            end else begin
              row   <= row + 1'b1;
              state <= S_MAC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  matvec_mac #(.IW(IW), .OW(OW), .AW(AW)) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (mac_clr),
    .en     (mac_en),
    .load   (mac_en && last_col),
    .a      (m_word),
    .b      (x_word),
    .result (output_data)
  );

endmodule

// File: tb/tb_matvec_stream.sv
// tb/tb_matvec_stream.sv - scoreboard bench for matvec_stream, K=8 IW=14 OW=28 (MATVEC_SAT_EN aware)
module tb_matvec_stream;

  logic               clk = 1'b0;
  logic               reset;
  logic               input_valid;
  logic               input_ready;
  logic signed [13:0] input_data;
  logic               new_matrix;
  logic               output_valid;
  logic               output_ready;
  logic signed [27:0] output_data;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_q[$];
  int     mbuf[64];
  int     xbuf[8];

  matvec_stream #(.K(8), .IW(14), .OW(28)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .new_matrix   (new_matrix),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: one pop per output transfer
  always @(negedge clk) begin
    if (!reset && output_valid && output_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", longint'(output_data), 0);
        n_fail += (output_data == 0) ? 1 : 0;
      end else begin
        check("y", longint'(output_data), exp_q.pop_front());
      end
    end
  end

  task automatic send(input int d, input bit nm, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        input_valid = 1'b0;
        input_data  = 'x;
        new_matrix  = 1'bx;
        @(posedge clk); #1;
      end
    end
    input_valid = 1'b1;
    input_data  = 14'(d);
    new_matrix  = nm;
    t = 0;
    while (!input_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) check("input_ready_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
    end
    input_valid = 1'b0;
    input_data  = 'x;
    new_matrix  = 1'bx;
  endtask

  task automatic send_txn(input bit nm, input bit gaps);
    if (nm)
      for (int i = 0; i < 64; i++) send(mbuf[i], (i == 0), gaps);
    for (int i = 0; i < 8; i++) send(xbuf[i], 1'b0, gaps);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    input_valid  = 1'b0;
    input_data   = '0;
    new_matrix   = 1'b0;
    output_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_input_ready", input_ready, 0);
    check("reset_output_valid", output_valid, 0);
    check("reset_output_data", output_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_input_ready", input_ready, 1);

    // 1: identity matrix, x=1..8, latency check
    for (int i = 0; i < 64; i++) mbuf[i] = (i / 8 == i % 8) ? 1 : 0;
    for (int i = 0; i < 8; i++) xbuf[i] = i + 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(i + 1);
    send_txn(1'b1, 1'b0);
    n = 0;
    while (!output_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_latency", n, 8);
    drain();

    // 2: reuse stored identity
    for (int i = 0; i < 8; i++) xbuf[i] = 2;
    for (int i = 0; i < 8; i++) exp_q.push_back(2);
    send_txn(1'b0, 1'b0);
    drain();

    // 3: negative extreme matrix
    for (int i = 0; i < 64; i++) mbuf[i] = -8192;
    for (int i = 0; i < 8; i++) xbuf[i] = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(-65536);
    send_txn(1'b1, 1'b1);
    drain();

    // 4: positive extreme, wraps or clamps
    for (int i = 0; i < 64; i++) mbuf[i] = 8191;
    for (int i = 0; i < 8; i++) xbuf[i] = 8191;
`ifdef MATVEC_SAT_EN
    for (int i = 0; i < 8; i++) exp_q.push_back(134217727);
`else
    for (int i = 0; i < 8; i++) exp_q.push_back(-131064);
`endif
    send_txn(1'b1, 1'b0);
    drain();

    // 5: backpressure; y[r] = 36*(r+1)
    for (int i = 0; i < 64; i++) mbuf[i] = i / 8 + 1;
    for (int i = 0; i < 8; i++) xbuf[i] = i + 1;
    exp_q.push_back(36);  exp_q.push_back(72);  exp_q.push_back(108); exp_q.push_back(144);
    exp_q.push_back(180); exp_q.push_back(216); exp_q.push_back(252); exp_q.push_back(288);
    output_ready = 1'b0;
    send_txn(1'b1, 1'b0);
    n = 0;
    while (!output_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_seen", output_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid_held", output_valid, 1);
      check("bp_data_held", output_data, 36);
      check("bp_input_ready", input_ready, 0);
    end
    output_ready = 1'b1;
    drain();

    // 6: gapped partial load, reset mid-matrix, then reuse -> zeros
    for (int i = 0; i < 64; i++) mbuf[i] = 100 + i;
    for (int i = 0; i < 30; i++) send(mbuf[i], (i == 0), 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_input_ready", input_ready, 0);
    check("mid_reset_output_valid", output_valid, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) xbuf[i] = i + 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(0);
    send_txn(1'b0, 1'b1);
    drain();

    repeat (5) @(posedge clk);
    #1;
    check("final_idle_ready", input_ready, 1);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
